// File: rtl/hid_report_uart.sv
// hid_report_uart: captures HID reports into a small FIFO and streams each one
// out as a framed 8N1 UART packet (0xA5, type, payload bytes, XOR checksum).
module hid_report_uart #(
  parameter int CLK_FREQ      = 12000000,
  parameter int BAUD          = 115200,
  parameter int DEPTH         = 4,
  parameter int PAYLOAD_BYTES = 8,
  parameter int ACT_HOLD      = 1200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        usb_report,
  input  logic [1:0]  usb_type,
  input  logic [63:0] hid_report,
  input  logic [3:0]  type_mask,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        act_led
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW  = $clog2(ACT_HOLD + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [3:0]    BYTE_LAST  = 4'(PAYLOAD_BYTES + 2);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(ACT_HOLD);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [HW-1:0] act_cnt_q, act_cnt_d;
  logic          ready_q;

  state_t        state_q;
  logic [65:0]   frame_q;
  logic [7:0]    chk_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    bit_q;
  logic [3:0]    byte_q;
  logic          tx_q;

  logic          push_req, push_ok, pop, drop, fifo_empty, fifo_full;
  logic [65:0]   head;
  logic [7:0]    head_chk;
  logic [7:0]    cur_byte;

  // ready_q masks the capture path until one full cycle after reset release
  assign push_req   = ready_q & usb_report & type_mask[usb_type];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = (state_q == LOAD);
  assign push_ok    = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  // FIFO pointers, occupancy, saturating drop counter and activity hold timer
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    act_cnt_d  = act_cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    if (push_ok)                 act_cnt_d = HOLD_LOAD;
    else if (act_cnt_q != '0)    act_cnt_d = act_cnt_q - 1'b1;
  end

  // Register the FIFO bookkeeping state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      act_cnt_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      act_cnt_q  <= act_cnt_d;
      ready_q    <= 1'b1;
    end
  end

  // Report storage; a full-FIFO push with a same-cycle pop overwrites the slot being read out
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {usb_type, hid_report};
  end

  // Checksum of the FIFO head, latched together with the frame on LOAD
  always_comb begin
    head     = mem[rd_ptr_q];
    head_chk = {6'b0, head[65:64]};
    for (int k = 0; k < PAYLOAD_BYTES; k++) head_chk = head_chk ^ head[8*k +: 8];
  end

  // Select the frame byte currently being serialised
  always_comb begin
    cur_byte = 8'hA5;
    if (byte_q == 4'd1) cur_byte = {6'b0, frame_q[65:64]};
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (byte_q == 4'(k + 2)) cur_byte = frame_q[8*k +: 8];
    end
    if (byte_q == BYTE_LAST) cur_byte = chk_q;
  end

  // Frame FSM: fetch head into the frame register, then shift out bytes back to back
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      frame_q <= '0;
      chk_q   <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          frame_q <= head;
          chk_q   <= head_chk;
          timer_q <= '0;
          bit_q   <= '0;
          byte_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= SEND;
        end
        SEND: begin
          if (timer_q == TIMER_LAST) begin
            timer_q <= '0;
            if (bit_q == 4'd9) begin
              bit_q <= '0;
              if (byte_q == BYTE_LAST) begin
                byte_q  <= '0;
                tx_q    <= 1'b1;
                state_q <= IDLE;
              end else begin
                byte_q <= byte_q + 4'd1;
                tx_q   <= 1'b0;
              end
            end else if (bit_q == 4'd8) begin
              bit_q <= 4'd9;
              tx_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= cur_byte[bit_q[2:0]];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign drop_cnt = drop_cnt_q;
  assign act_led  = (act_cnt_q != '0);

endmodule

// File: tb/tb_hid_report_uart.sv
// tb_hid_report_uart: table-driven vectors plus hand-written overflow, saturation,
// reset-abort and activity-LED sequences; a UART monitor checks bytes against a queue.
module tb_hid_report_uart;

  localparam int CLK_FREQ = 12000000;
  localparam int BAUD     = 3000000;
  localparam int DEPTH    = 4;
  localparam int PAYLOAD  = 8;
  localparam int ACT_HOLD = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        usb_report = 1'b0;
  logic [1:0]  usb_type = 2'd0;
  logic [63:0] hid_report = '0;
  logic [3:0]  type_mask = 4'd0;
  logic        uart_tx, busy, act_led;
  logic [7:0]  drop_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  mask;
    logic [63:0] report;
    logic        accept;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs [7];

  hid_report_uart #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH),
    .PAYLOAD_BYTES(PAYLOAD), .ACT_HOLD(ACT_HOLD)
  ) dut (
    .clk(clk), .resetn(resetn), .usb_report(usb_report), .usb_type(usb_type),
    .hid_report(hid_report), .type_mask(type_mask), .uart_tx(uart_tx),
    .busy(busy), .drop_cnt(drop_cnt), .act_led(act_led)
  );

  always #5 clk = ~clk;

  // Compare one value and keep the running tallies
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [7:0] calcChk(input logic [1:0] t, input logic [63:0] r);
    logic [7:0] c;
    c = {6'b0, t};
    for (int k = 0; k < PAYLOAD; k++) c = c ^ r[8*k +: 8];
    return c;
  endfunction

  // Queue the bytes of one expected frame
  task automatic pushFrame(input logic [1:0] t, input logic [63:0] r, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    exp_q.push_back({6'b0, t});
    for (int k = 0; k < PAYLOAD; k++) exp_q.push_back(r[8*k +: 8]);
    exp_q.push_back(chk);
  endtask

  // One-cycle report pulse, called at a falling edge; returns 1 time unit after the capturing edge
  task automatic applyStimulus(input logic [1:0] t, input logic [3:0] m, input logic [63:0] r,
                               input logic accept, input logic [7:0] chk);
    usb_type   = t;
    type_mask  = m;
    hid_report = r;
    usb_report = 1'b1;
    if (accept) pushFrame(t, r, chk);
    @(posedge clk);
    #1 usb_report = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // UART receiver: samples each bit near its middle on falling edges
  int         mon_cnt = 0;
  bit         mon_active = 1'b0;
  logic [7:0] mon_byte = 8'd0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!resetn) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 1) begin
        checkOutput("start_bit", {63'd0, uart_tx}, 64'd0);
      end else if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % 4) == 0) begin
        mon_byte[(mon_cnt - 5) / 4] = uart_tx;
      end else if (mon_cnt == 37) begin
        checkOutput("stop_bit", {63'd0, uart_tx}, 64'd1);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL uart_byte: got 0x%02h, expected no byte", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("uart_byte", {56'd0, mon_byte}, {56'd0, mon_exp});
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{typ: 2'd1, mask: 4'b1110, report: 64'h0807060504030201, accept: 1'b1, chk: 8'h09};
    vecs[1] = '{typ: 2'd2, mask: 4'b0010, report: 64'h1122334455667788, accept: 1'b0, chk: 8'h00};
    vecs[2] = '{typ: 2'd2, mask: 4'b0100, report: 64'h0000000000000000, accept: 1'b1, chk: 8'h02};
    vecs[3] = '{typ: 2'd3, mask: 4'b1000, report: 64'hFFFFFFFFFFFFFFFF, accept: 1'b1, chk: 8'h03};
    vecs[4] = '{typ: 2'd0, mask: 4'b0001, report: 64'h00000000000000AA, accept: 1'b1, chk: 8'hAA};
    vecs[5] = '{typ: 2'd3, mask: 4'b0111, report: 64'hA5A5A5A5A5A5A5A5, accept: 1'b0, chk: 8'h00};
    vecs[6] = '{typ: 2'd1, mask: 4'b1111, report: 64'h123456789ABCDEF0, accept: 1'b1, chk: 8'h01};

    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx",     {63'd0, uart_tx}, 64'd1);
    checkOutput("reset_busy",   {63'd0, busy},    64'd0);
    checkOutput("reset_drop",   {56'd0, drop_cnt}, 64'd0);
    checkOutput("reset_actled", {63'd0, act_led}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single-report vectors: latency, frame length and masking
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].typ, vecs[i].mask, vecs[i].report, vecs[i].accept, vecs[i].chk);
      checkOutput($sformatf("v%0d_act_led", i), {63'd0, act_led}, {63'd0, vecs[i].accept});
      @(negedge clk);
      checkOutput($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].accept});
      @(negedge clk);
      checkOutput($sformatf("v%0d_tx_t1", i), {63'd0, uart_tx}, 64'd1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_tx_t2", i), {63'd0, uart_tx}, vecs[i].accept ? 64'd0 : 64'd1);
      repeat (439) @(negedge clk);
      checkOutput($sformatf("v%0d_busy_t441", i), {63'd0, busy}, {63'd0, vecs[i].accept});
      @(negedge clk);
      checkOutput($sformatf("v%0d_busy_t442", i), {63'd0, busy}, 64'd0);
      checkOutput($sformatf("v%0d_tx_idle", i), {63'd0, uart_tx}, 64'd1);
      checkOutput($sformatf("v%0d_drop", i), {56'd0, drop_cnt}, 64'd0);
      checkOutput($sformatf("v%0d_queue", i), 64'(exp_q.size()), 64'd0);
    end

    // Overflow: six back-to-back reports, the sixth finds the FIFO full
    @(negedge clk);
    type_mask = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      usb_type   = 2'(i % 4);
      hid_report = {32'(i * 3 + 1), 32'hCAFE0000 ^ 32'(i)};
      usb_report = 1'b1;
      if (i < 5) pushFrame(usb_type, hid_report, calcChk(usb_type, hid_report));
      @(negedge clk);
    end
    usb_report = 1'b0;
    checkOutput("overflow_drop", {56'd0, drop_cnt}, 64'd1);
    waitDrain(5 * 442 + 50, "overflow");
    checkOutput("overflow_drop_final", {56'd0, drop_cnt}, 64'd1);

    // Saturation: 300 drops against a full FIFO
    doReset();
    checkOutput("sat_reset_drop", {56'd0, drop_cnt}, 64'd0);
    type_mask = 4'b1111;
    for (int i = 0; i < 305; i++) begin
      usb_type   = 2'((i + 1) % 4);
      hid_report = {32'hBEEF0000 | 32'(i), 32'(i * 7)};
      usb_report = 1'b1;
      if (i < 5) pushFrame(usb_type, hid_report, calcChk(usb_type, hid_report));
      @(negedge clk);
      if (i == 258) checkOutput("sat_drop_254", {56'd0, drop_cnt}, 64'd254);
      if (i == 259) checkOutput("sat_drop_255", {56'd0, drop_cnt}, 64'd255);
    end
    usb_report = 1'b0;
    checkOutput("sat_drop_hold", {56'd0, drop_cnt}, 64'd255);
    waitDrain(5 * 442 + 50, "saturation");

    // Reset 100 cycles into a frame, with a report held through reset and release
    @(negedge clk);
    applyStimulus(2'd1, 4'b1110, 64'h0807060504030201, 1'b1, 8'h09);
    repeat (99) @(posedge clk);
    #1;
    resetn     = 1'b0;
    usb_report = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("abort_tx",     {63'd0, uart_tx}, 64'd1);
    checkOutput("abort_busy",   {63'd0, busy},    64'd0);
    checkOutput("abort_drop",   {56'd0, drop_cnt}, 64'd0);
    checkOutput("abort_actled", {63'd0, act_led}, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 usb_report = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("release_busy",   {63'd0, busy},    64'd0);
    checkOutput("release_tx",     {63'd0, uart_tx}, 64'd1);
    checkOutput("release_actled", {63'd0, act_led}, 64'd0);
    applyStimulus(2'd3, 4'b1000, 64'hDEADBEEF01234567, 1'b1, calcChk(2'd3, 64'hDEADBEEF01234567));
    waitDrain(600, "after_reset");
    checkOutput("after_reset_drop", {56'd0, drop_cnt}, 64'd0);

    // Activity LED: pushes in cycles 0 and 10 keep it lit through cycle 26
    @(negedge clk);
    type_mask = 4'b1111;
    usb_type  = 2'd2;
    for (int k = 0; k <= 30; k++) begin
      checkOutput($sformatf("act_led_c%0d", k), {63'd0, act_led},
                  (k >= 1 && k <= 26) ? 64'd1 : 64'd0);
      usb_report = (k == 0 || k == 10);
      if (usb_report) begin
        hid_report = {32'h5A5A0000, 32'(k)};
        pushFrame(usb_type, hid_report, calcChk(usb_type, hid_report));
      end
      @(negedge clk);
    end
    usb_report = 1'b0;
    waitDrain(1000, "act_led");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hid_report_uart.md
HID_REPORT_UART -- requirements
Module: hid_report_uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; DIV = CLK_FREQ/BAUD (integer floor, DIV >= 2).
REQ-003 SHALL have parameter DEPTH, default 4, report FIFO depth (power of 2, 2..16).
REQ-004 SHALL have parameter PAYLOAD_BYTES, default 8, report bytes sent per frame (1..8).
REQ-005 SHALL have parameter ACT_HOLD, default 1200000, activity LED hold time in cycles.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port usb_report  input  1  one-cycle pulse, new HID report valid.
REQ-009 SHALL have port usb_type  input  2  device type of report (0 none, 1 keyboard, 2 mouse, 3 gamepad).
REQ-010 SHALL have port hid_report  input  64  raw report; byte k = hid_report[8k+7:8k].
REQ-011 SHALL have port type_mask  input  4  capture enable per type; bit n enables usb_type n.
REQ-012 SHALL have port uart_tx  output  1  8N1 serial output, idle high.
REQ-013 SHALL have port busy  output  1  high while a frame is in flight or FIFO non-empty.
REQ-014 SHALL have port drop_cnt  output  8  count of reports lost to FIFO full, saturating.
REQ-015 SHALL have port act_led  output  1  high while capture activity is recent.

Function
REQ-016 Capture: on usb_report=1 with type_mask[usb_type]=1, SHALL push {usb_type, hid_report} into FIFO; masked reports ignored, no counter change.
REQ-017 Full: push with count=DEPTH and no pop in the same cycle SHALL be dropped, drop_cnt += 1, holding at 255.
REQ-018 Simultaneous push and pop when full SHALL accept the push; count unchanged.
REQ-019 FSM states: IDLE, LOAD, SEND. IDLE->LOAD when FIFO non-empty; LOAD pops head into frame register (1 cycle) ->SEND; SEND->IDLE after last stop bit completes.
REQ-020 Frame SHALL be PAYLOAD_BYTES+3 bytes: 0xA5, {6'b0,type}, payload bytes 0..PAYLOAD_BYTES-1 in ascending order, checksum.
REQ-021 Checksum SHALL be XOR of type byte and all payload bytes (0xA5 excluded).
REQ-022 Each byte SHALL be start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly DIV cycles; no gap between bytes within a frame.
REQ-023 Latency: push at edge t into empty FIFO with FSM IDLE SHALL drive uart_tx low (start bit) from edge t+2.
REQ-024 Back-to-back frames: after last stop bit, next frame start bit SHALL begin within 2 cycles if FIFO non-empty.
REQ-025 Frame register SHALL be stable during SEND; new captures never alter an in-flight frame.
REQ-026 busy SHALL be 1 when FSM not IDLE or FIFO count > 0, else 0.
REQ-027 act_led SHALL assert the cycle after an accepted push and stay high ACT_HOLD cycles after the last accepted push (retriggerable); dropped or masked reports do not retrigger.

Reset
REQ-028 resetn=0 SHALL asynchronously force uart_tx=1, busy=0, drop_cnt=0, act_led=0, FSM IDLE, FIFO empty, bit timer and byte index 0.
REQ-029 Reset mid-frame SHALL abort the frame; after release no partial frame resumes and the first frame transmitted is from a new capture.
REQ-030 usb_report asserted during reset or the release cycle SHALL be ignored.

Verification (CLK_FREQ=12000000, BAUD=3000000 -> DIV=4, PAYLOAD_BYTES=8, DEPTH=4, ACT_HOLD=16)
REQ-031 Single keyboard report type=1, hid_report=64'h0807060504030201, mask=4'b1110 -> uart bytes A5 01 01 02 03 04 05 06 07 08 09 (checksum 0x09), 440 cycles, start bit at t+2.
REQ-032 Mask test: type=2 with mask=4'b0010 -> uart_tx stays high, busy=0, drop_cnt=0, act_led=0.
REQ-033 Overflow: 6 reports in 6 consecutive cycles -> 5 frames sent in push order (1 in flight + 4 queued), drop_cnt=1.
REQ-034 Saturation: 300 drops while FIFO full -> drop_cnt=255.
REQ-035 Reset asserted 100 cycles into a frame -> uart_tx=1 immediately, busy=0; after release, one new report -> one complete correct frame only.
REQ-036 act_led: pushes at cycles 0 and 10 -> act_led high from cycle 1 through cycle 26, low at cycle 27.
